// File: rtl/wr_req_arbiter.sv
// wr_req_arbiter
// Round-robin arbiter that shares one wr_req_fsm write port among NUM_REQ
// requesters. The winning request's address and data are latched, a single
// wr_req pulse is sent to the FSM, and the owner receives a done pulse once
// wr_out acknowledges the write.
// Optional feature: define WR_ARB_TIMEOUT_EN to add an ack timeout that
// abandons the write after TO_CYC WAIT cycles and pulses err[owner].
module wr_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int TO_CYC  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic [NUM_REQ-1:0]    err,
    output logic                  wr_req,
    output logic [AW-1:0]         wr_addr,
    output logic [DW-1:0]         wr_data,
    input  logic                  wr_out,
    output logic                  busy,
    output logic [2:0]            owner
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TO_CYC < 2) begin : g_param_check
        $error("wr_req_arbiter: NUM_REQ must be 2..8 and TO_CYC at least 2");
    end

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [2:0]         LAST_IDX = 3'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [2:0]           r_ptr;
    logic [2:0]           r_owner;
    logic [2:0]           w_pick;
    logic [2:0]           w_ptr_adv;
    logic                 w_found;
    logic                 w_timeout;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_wr_req;
    logic                 r_busy;
    logic [AW-1:0]        r_wr_addr;
    logic [DW-1:0]        r_wr_data;

    // Round-robin search: first set req bit scanning r_ptr, r_ptr+1, ... (mod NUM_REQ).
    always_comb begin
        int idx;
        // NOTE: every variable written here gets a value before any condition,
        // so no path leaves it unassigned and no latch is inferred.
        w_found = 1'b0;
        w_pick  = '0;
        idx     = 0;
        // Scan from the far end so the closest candidate to r_ptr wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                w_found = 1'b1;
                w_pick  = 3'(idx);
            end
        end
    end

    // Pointer value after the current owner finishes: the next requester, wrapping.
    assign w_ptr_adv = (r_owner == LAST_IDX) ? 3'd0 : r_owner + 3'd1;

`ifdef WR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);

    logic [CW-1:0]      r_cnt;
    logic [NUM_REQ-1:0] r_err;

    // Counts WAIT cycles; held at zero elsewhere so it starts clean on every WAIT entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // An ack in the final WAIT cycle takes priority over the timeout.
    assign w_timeout = (r_state == S_WAIT) && !wr_out && (r_cnt == CW'(TO_CYC - 1));

    // Timeout pulse to the owner in the cycle the arbiter falls back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            r_err <= w_timeout ? (ONE_HOT0 << r_owner) : '0;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = '0;
`endif

    // Next-state logic: arbitrate in IDLE, one ISSUE cycle, wait for ack, one DONE cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: w_next = wr_out ? S_DONE : S_WAIT;
            S_WAIT: begin
                if (wr_out) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, pointer and registered outputs; pulses are derived from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_wr_req  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state  <= w_next;
            r_busy   <= (w_next != S_IDLE);
            r_gnt    <= '0;
            r_wr_req <= 1'b0;
            r_done   <= '0;
            if (r_state == S_IDLE && w_found) begin
                r_gnt     <= ONE_HOT0 << w_pick;
                r_wr_req  <= 1'b1;
                r_owner   <= w_pick;
                r_wr_addr <= req_addr[w_pick*AW +: AW];
                r_wr_data <= req_data[w_pick*DW +: DW];
            end
            if (w_next == S_DONE) begin
                r_done <= ONE_HOT0 << r_owner;
            end
            if (r_state == S_DONE || w_timeout) begin
                r_ptr <= w_ptr_adv;
            end
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign wr_req  = r_wr_req;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign owner   = r_owner;

endmodule

// File: tb/tb_wr_req_arbiter.sv
// tb_wr_req_arbiter
// Directed scenarios with literal expectations, followed by randomized traffic.
// A transaction-level reference model predicts every output each cycle and a
// single compare process checks the DUT against it on the falling clock edge.
module tb_wr_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic            wr_req;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            wr_out;
    logic            busy;
    logic [2:0]      owner;

    int n_checks = 0;
    int n_fail   = 0;

    wr_req_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .TO_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_out   (wr_out),
        .busy     (busy),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction is: grant cycle, zero or more ack-wait cycles, then a done
    // cycle (ack seen) or an abandon (timeout); a new arbitration follows.
    bit            m_busy  = 1'b0;   // a transaction is in progress
    bit            m_fin   = 1'b0;   // current cycle is the completion cycle
    int            m_age   = 0;      // cycles elapsed since the grant cycle
    int            m_owner = 0;
    int            m_ptr   = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    logic [N-1:0]  e_gnt   = '0;
    logic [N-1:0]  e_done  = '0;
    logic [N-1:0]  e_err   = '0;
    logic          e_wr_req = 1'b0;
    logic          e_busy  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_fin = 1'b0; m_age = 0; m_ptr = 0;
            e_gnt = '0; e_done = '0; e_err = '0; e_wr_req = 1'b0;
        end else begin
            e_gnt = '0; e_done = '0; e_err = '0; e_wr_req = 1'b0;
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (req[i]) begin
                        m_busy = 1'b1; m_fin = 1'b0; m_age = 0; m_owner = i;
                        m_addr = req_addr[i*AW +: AW];
                        m_data = req_data[i*DW +: DW];
                        e_gnt[i] = 1'b1;
                        e_wr_req = 1'b1;
                        break;
                    end
                end
            end else if (m_fin) begin
                m_busy = 1'b0; m_fin = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end else if (wr_out) begin
                m_fin = 1'b1;
                e_done[m_owner] = 1'b1;
            end else begin
`ifdef WR_ARB_TIMEOUT_EN
                if (m_age == TO) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                    e_err[m_owner] = 1'b1;
                end else begin
                    m_age++;
                end
`else
                m_age++;
`endif
            end
        end
        e_busy = m_busy;
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        check("busy",   32'(busy),   32'(e_busy));
        check("gnt",    32'(gnt),    32'(e_gnt));
        check("wr_req", 32'(wr_req), 32'(e_wr_req));
        check("done",   32'(done),   32'(e_done));
        check("err",    32'(err),    32'(e_err));
        if (e_busy) begin
            check("owner",   32'(owner),   32'(m_owner));
            check("wr_addr", 32'(wr_addr), 32'(m_addr));
            check("wr_data", 32'(wr_data), 32'(m_data));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Waits (bounded) for a gnt pulse; lat counts falling edges from the call.
    task automatic wait_gnt(output int idx, output int lat);
        idx = -1;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                idx = first_idx(gnt);
                lat = c;
                break;
            end
        end
        check("gnt_seen", 32'(gnt != '0), 32'd1);
    endtask

    // Called at the falling edge of the grant cycle: ack in the next cycle.
    task automatic ack_after(input logic [N-1:0] next_req);
        tick();
        wr_out = 1'b1;
        req    = next_req;
        tick();
        wr_out = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int idx, lat;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1; req = '0; req_addr = '0; req_data = '0; wr_out = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt",  32'(gnt),  32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single write from requester 0, acked one cycle after wr_req.
        req = 4'b0001;
        req_addr[0 +: AW] = 8'h12;
        req_data[0 +: DW] = 16'hBEEF;
        wait_gnt(idx, lat);
        check("t1_idx", 32'(idx), 32'd0);
        check("t1_lat", 32'(lat), 32'd2);
        check("t1_wr_req", 32'(wr_req), 32'd1);
        check("t1_addr", 32'(wr_addr), 32'h12);
        check("t1_data", 32'(wr_data), 32'hBEEF);
        ack_after(4'b0000);
        @(negedge clk);
        check("t1_done", 32'(done), 32'b0001);
        check("t1_busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_done_clr", 32'(done), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // All requesting: rotation 0,1,2,3,0 from a fresh reset.
        tick();
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = AW'(8'h40 + i);
            req_data[i*DW +: DW] = DW'(16'h1000 + i);
        end
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(idx, lat);
            check("t2_order", 32'(idx), 32'(exp_order[g]));
            check("t2_lat", 32'(lat), (g == 0) ? 32'd2 : 32'd3);
            ack_after((g == 4) ? 4'b0101 : 4'b1111);
        end

        // Pointer now at 1: requester 2 wins over 0.
        wait_gnt(idx, lat);
        check("t3_idx", 32'(idx), 32'd2);
        check("t3_addr", 32'(wr_addr), 32'h42);
        check("t3_data", 32'(wr_data), 32'h1002);
        ack_after(4'b0001);
        wait_gnt(idx, lat);
        check("t3_idx2", 32'(idx), 32'd0);
        ack_after(4'b0000);

        // Stray ack in DONE and IDLE: one done pulse only, nothing restarts.
        @(negedge clk);
        tick();
        req = 4'b0010;
        wait_gnt(idx, lat);
        tick();
        wr_out = 1'b1;
        req    = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        check("t4_done", 32'(done), 32'b0010);
        @(negedge clk);
        check("t4_done_once", 32'(done), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("t4_still_idle", 32'(busy), 32'd0);
        tick();
        wr_out = 1'b0;

        // Reset during WAIT: outputs clear at once, then requester 3 is served.
        req = 4'b0100;
        wait_gnt(idx, lat);
        tick();
        rst = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_owner", 32'(owner), 32'd0);
        check("t5_addr", 32'(wr_addr), 32'd0);
        check("t5_data", 32'(wr_data), 32'd0);
        tick();
        rst = 1'b0;
        req = 4'b1000;
        wait_gnt(idx, lat);
        check("t5_idx", 32'(idx), 32'd3);
        check("t5_lat", 32'(lat), 32'd2);
        ack_after(4'b0000);

`ifdef WR_ARB_TIMEOUT_EN
        // No ack at all: err arrives in the cycle after the TO_CYC-th WAIT cycle.
        @(negedge clk);
        tick();
        req = 4'b0001;
        wait_gnt(idx, lat);
        tick();
        req = 4'b0000;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (err != '0) begin
                lat = c;
                break;
            end
        end
        check("t6_err", 32'(err), 32'b0001);
        check("t6_delay", 32'(lat), 32'(TO + 1));
`endif

        // Randomized traffic, acks and occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] && gnt[i] && $urandom_range(0, 3) != 0) begin
                    req[i] = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    req[i] = ~req[i];
                end
            end
            req_addr = $urandom();
            req_data = {$urandom(), $urandom()};
            wr_out   = ($urandom_range(0, 2) == 0);
        end
        tick();
        rst = 1'b0;
        wr_out = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
